// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage feeding control_unit/decoder. Holds a word-addressed
//   program counter, reads instruction memory over a req/ack handshake, presents
//   {instr_out, pc_out} to decode with a valid/stall handshake and redirects on a
//   rising edge of the control unit's j_signal. All outputs come straight from
//   flops; there is no combinational input-to-output path.
//
// Ports
//   clk, rst                  clock (posedge) and asynchronous active-low reset
//   j_signal, jump            jump request (level) and jump target PC
//   stall                     decode cannot accept instr_out this cycle
//   imem_req, imem_addr       instruction memory request and word address
//   imem_ack, imem_rdata      memory answer strobe and instruction word
//   instr_out, pc_out         fetched instruction and its PC
//   instr_valid               instr_out/pc_out hold a real instruction
//   fetch_err                 sticky memory timeout flag (cleared only by reset)

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        j_signal,
   input  logic [31:0] jump,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   output logic        fetch_err
);

   localparam int unsigned    CNT_W    = $clog2(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             imem_req_q, imem_req_d;
   logic [31:0]      imem_addr_q, imem_addr_d;
   logic [31:0]      instr_out_q, instr_out_d;
   logic [31:0]      pc_out_q, pc_out_d;
   logic             instr_valid_q, instr_valid_d;
   logic             fetch_err_q, fetch_err_d;
   logic             flush_q, flush_d;
   logic             j_q, j_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic redirect;
   logic slot_free;
   logic pending;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the
      // case/if tree leaves a signal unassigned and infers a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      imem_req_d    = imem_req_q;
      imem_addr_d   = imem_addr_q;
      instr_out_d   = instr_out_q;
      pc_out_d      = pc_out_q;
      instr_valid_d = instr_valid_q;
      fetch_err_d   = fetch_err_q;
      flush_d       = flush_q;
      wait_cnt_d    = wait_cnt_q;
      j_d           = j_signal;

      // Only the rising edge of j_signal redirects; a held level is ignored.
      redirect  = j_signal & ~j_q;
      slot_free = ~instr_valid_q | ~stall;
      // A request is on the bus and memory has not answered this cycle.
      pending   = imem_req_q & ~imem_ack;

      if (state_q == S_REQ || state_q == S_HOLD) begin
         if (instr_valid_q && !stall) begin
            instr_valid_d = 1'b0;
            instr_out_d   = NOP;
         end
         if (redirect) begin
            pc_d          = jump;
            instr_valid_d = 1'b0;
            instr_out_d   = NOP;
         end
      end

      case (state_q)
         S_IDLE: begin
            // The request itself is raised from REQ on the following edge.
            state_d = S_REQ;
         end

         S_REQ: begin
            if (pending && wait_cnt_q == CNT_LAST) begin
               state_d       = S_ERR;
               fetch_err_d   = 1'b1;
               imem_req_d    = 1'b0;
               instr_valid_d = 1'b0;
               instr_out_d   = NOP;
            end else if (pending) begin
               // Address stays on the bus; a redirect now marks the eventual
               // answer as stale instead of abandoning the handshake.
               wait_cnt_d = wait_cnt_q + 1'b1;
               if (redirect) flush_d = 1'b1;
            end else if (redirect || !imem_req_q || flush_q) begin
               // Nothing usable on the bus: any answer this cycle belongs to
               // an old address, so drop it and issue at the current target.
               flush_d     = 1'b0;
               wait_cnt_d  = '0;
               imem_req_d  = 1'b1;
               imem_addr_d = redirect ? jump : pc_q;
            end else if (slot_free) begin
               wait_cnt_d    = '0;
               instr_out_d   = imem_rdata;
               pc_out_d      = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + 32'd1;
               imem_addr_d   = pc_q + 32'd1;
            end else begin
               // Decode is stalled on a valid word: the answer is not taken and
               // the same pc is read again once the slot frees.
               wait_cnt_d = '0;
               imem_req_d = 1'b0;
               state_d    = S_HOLD;
            end
         end

         S_HOLD: begin
            if (redirect || slot_free) begin
               state_d     = S_REQ;
               imem_req_d  = 1'b1;
               imem_addr_d = redirect ? jump : pc_q;
            end
         end

         default: begin
            // S_ERR holds everything until reset.
         end
      endcase
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         imem_req_q    <= 1'b0;
         imem_addr_q   <= RESET_PC;
         instr_out_q   <= NOP;
         pc_out_q      <= 32'd0;
         instr_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         flush_q       <= 1'b0;
         j_q           <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         imem_req_q    <= imem_req_d;
         imem_addr_q   <= imem_addr_d;
         instr_out_q   <= instr_out_d;
         pc_out_q      <= pc_out_d;
         instr_valid_q <= instr_valid_d;
         fetch_err_q   <= fetch_err_d;
         flush_q       <= flush_d;
         j_q           <= j_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign instr_out   = instr_out_q;
   assign pc_out      = pc_out_q;
   assign instr_valid = instr_valid_q;
   assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Bench for fetch_unit. A behavioural memory answers reads with 0x100+addr
//   after a programmable number of wait cycles; expected {pc, instr} pairs are
//   queued as each scenario starts and retired as decode consumes them. A second
//   instance with RESET_PC = FFFF_FFFF exercises PC wrap-around.

module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        j_signal;
   logic [31:0] jump;
   logic        stall;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instr_out, pc_out;
   logic        instr_valid, fetch_err;

   logic        imem_req_w, imem_ack_w;
   logic [31:0] imem_addr_w, imem_rdata_w;
   logic [31:0] instr_out_w, pc_out_w;
   logic        instr_valid_w, fetch_err_w;

   bit    mem_en;
   int    mem_lat;
   int    lat_cnt;
   int    checks;
   int    failures;
   bit    sb_en;
   item_t sb_q[$];
   item_t sb_exp;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .j_signal(j_signal), .jump(jump), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr_out(instr_out), .pc_out(pc_out),
      .instr_valid(instr_valid), .fetch_err(fetch_err)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
      .clk(clk), .rst(rst), .j_signal(j_signal), .jump(jump), .stall(stall),
      .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w),
      .imem_rdata(imem_rdata_w), .instr_out(instr_out_w), .pc_out(pc_out_w),
      .instr_valid(instr_valid_w), .fetch_err(fetch_err_w)
   );

   // Memory model: ack after mem_lat idle cycles of a held request.
   always @(posedge clk or negedge rst) begin
      if (!rst)                        lat_cnt <= 0;
      else if (imem_req && !imem_ack) lat_cnt <= lat_cnt + 1;
      else                             lat_cnt <= 0;
   end
   assign imem_ack     = mem_en && imem_req && (lat_cnt == mem_lat);
   assign imem_rdata   = imem_addr + 32'h100;
   assign imem_ack_w   = imem_req_w;
   assign imem_rdata_w = ~imem_addr_w;

   // Scoreboard: an item is retired on each cycle decode takes it.
   always @(negedge clk) begin
      if (sb_en && rst && instr_valid && !stall) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected pc_out=%h instr_out=%h expected=none", pc_out, instr_out);
         end else begin
            sb_exp = sb_q.pop_front();
            if (pc_out !== sb_exp.pc || instr_out !== sb_exp.instr) begin
               failures++;
               $display("FAIL sb_item pc_out=%h instr_out=%h expected pc=%h instr=%h",
                        pc_out, instr_out, sb_exp.pc, sb_exp.instr);
            end
         end
      end
   end

   task automatic do_reset();
      rst      = 1'b0;
      j_signal = 1'b0;
      stall    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic push_item(input logic [31:0] pc);
      item_t it;
      it.pc    = pc;
      it.instr = pc + 32'h100;
      sb_q.push_back(it);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({imem_req, instr_valid, fetch_err} !== 3'b000 || imem_addr !== 32'h0 ||
          instr_out !== 32'h13 || pc_out !== 32'h0) begin
         failures++;
         $display("FAIL por_state req=%b valid=%b err=%b addr=%h instr=%h pc=%h expected 0,0,0,0,13,0",
                  imem_req, instr_valid, fetch_err, imem_addr, instr_out, pc_out);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b0) begin
         failures++;
         $display("FAIL req_edge1 imem_req=%b expected 0", imem_req);
      end
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL req_edge2 imem_req=%b addr=%h expected 1 addr 0", imem_req, imem_addr);
      end
      // Stream four words, then starve memory so the request hangs at addr 4.
      mem_en = 1'b1;
      repeat (4) @(posedge clk);
      #1 mem_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
         failures++;
         $display("FAIL req_held imem_req=%b addr=%h expected 1 addr 4", imem_req, imem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_out !== 32'h13 ||
          instr_valid !== 1'b0 || pc_out !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset req=%b addr=%h instr=%h valid=%b pc=%h expected 0,0,13,0,0",
                  imem_req, imem_addr, instr_out, instr_valid, pc_out);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b0) begin
         failures++;
         $display("FAIL rerelease_edge1 imem_req=%b expected 0", imem_req);
      end
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL rerelease_edge2 imem_req=%b addr=%h expected 1 addr 0", imem_req, imem_addr);
      end
   endtask

   task automatic test_stream();
      bit seen;
      do_reset();
      mem_lat = 0;
      mem_en  = 1'b1;
      for (int i = 0; i < 4; i++) push_item(32'(i));
      sb_en = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         seen = instr_valid;
      end
      for (int k = 0; k < 4; k++) begin
         if (k != 0) begin
            @(posedge clk); #1;
         end
         checks++;
         if (instr_valid !== 1'b1 || pc_out !== 32'(k) || instr_out !== 32'h100 + 32'(k)) begin
            failures++;
            $display("FAIL stream_%0d valid=%b pc=%h instr=%h expected 1 pc %h instr %h",
                     k, instr_valid, pc_out, instr_out, 32'(k), 32'h100 + 32'(k));
         end
      end
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      sb_en = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL stream_drain left=%0d expected 0", sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_stall();
      bit seen;
      do_reset();
      mem_lat = 0;
      mem_en  = 1'b1;
      for (int i = 0; i < 6; i++) push_item(32'(i));
      sb_en = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         seen = instr_valid && pc_out == 32'h2;
      end
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b1 || pc_out !== 32'h2 || instr_out !== 32'h102) begin
            failures++;
            $display("FAIL stall_hold_%0d req=%b valid=%b pc=%h instr=%h expected 0,1,2,102",
                     c, imem_req, instr_valid, pc_out, instr_out);
         end
      end
      stall = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         seen = instr_valid;
      end
      checks++;
      if (!seen || pc_out !== 32'h3) begin
         failures++;
         $display("FAIL stall_resume valid=%b pc=%h expected 1 pc 3", seen, pc_out);
      end
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      sb_en = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL stall_drain left=%0d expected 0", sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_redirect();
      bit seen;
      do_reset();
      mem_lat = 3;
      mem_en  = 1'b1;
      for (int i = 0; i < 5; i++) push_item(32'(i));
      for (int i = 0; i < 3; i++) push_item(32'h40 + 32'(i));
      sb_en = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         seen = imem_req && imem_addr == 32'h5;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL redir_reach_addr5 seen=0 expected 1");
      end
      @(posedge clk); #1;
      j_signal = 1'b1;
      jump     = 32'h40;
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h5 || instr_valid !== 1'b0 || instr_out !== 32'h13) begin
         failures++;
         $display("FAIL redir_flush req=%b addr=%h valid=%b instr=%h expected 1,5,0,13",
                  imem_req, imem_addr, instr_valid, instr_out);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         failures++;
         $display("FAIL redir_target req=%b addr=%h expected 1 addr 40", imem_req, imem_addr);
      end
      @(posedge clk); #1;
      j_signal = 1'b0;
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      sb_en = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL redir_drain left=%0d expected 0", sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_wrap();
      bit seen;
      do_reset();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         seen = instr_valid_w;
      end
      checks++;
      if (!seen || pc_out_w !== 32'hFFFF_FFFF || instr_out_w !== 32'h0) begin
         failures++;
         $display("FAIL wrap_first valid=%b pc=%h instr=%h expected 1 pc ffffffff instr 0",
                  seen, pc_out_w, instr_out_w);
      end
      @(posedge clk); #1;
      checks++;
      if (instr_valid_w !== 1'b1 || pc_out_w !== 32'h0 || instr_out_w !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL wrap_second valid=%b pc=%h instr=%h expected 1 pc 0 instr ffffffff",
                  instr_valid_w, pc_out_w, instr_out_w);
      end
   endtask

   task automatic test_timeout();
      int n;
      mem_en = 1'b0;
      do_reset();
      for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         n++;
         if (fetch_err === 1'b1) break;
      end
      checks++;
      if (fetch_err !== 1'b1 || n != 16) begin
         failures++;
         $display("FAIL timeout_cycles err=%b cycles=%0d expected 1 after 16", fetch_err, n);
      end
      mem_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL timeout_sticky req=%b err=%b valid=%b expected 0,1,0",
                  imem_req, fetch_err, instr_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (fetch_err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_clear err=%b expected 0", fetch_err);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      j_signal = 1'b0;
      jump     = 32'h0;
      stall    = 1'b0;
      mem_en   = 1'b0;
      mem_lat  = 0;
      sb_en    = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
